// File: rtl/mem_copy_dma_pkg.sv
// Shared mem_if protocol types and bus configuration for the word-copy DMA.
package mem_copy_dma_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_MASK_W = MEM_DATA_W / 8;

  // Byte distance between consecutive words
  localparam logic [MEM_ADDR_W-1:0] WORD_STRIDE = MEM_ADDR_W'(MEM_DATA_W / 8);

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] req_addr;
    logic [MEM_DATA_W-1:0] req_data;
    logic [MEM_MASK_W-1:0] req_mask;
    mem_type_e             req_type;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0] resp_data;
    logic                  resp_last;
  } mem_resp_t;

endpackage

// File: rtl/mem_copy_dma.sv
// Single-channel word-copy DMA: reads one word, writes it back out, repeats LEN times.
// All request-side outputs are registered; one mem_if transaction outstanding at a time.
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [MEM_ADDR_W-1:0] src_addr,
  input  logic [MEM_ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done_irq,
  input  logic                  irq_clr,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output mem_req_t              mem_req,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  mem_resp_t             mem_resp
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_RESP = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = S_IDLE,
    RD_REQ  = S_RD_REQ,
    RD_RESP = S_RD_RESP,
    WR_REQ  = S_WR_REQ,
    WR_RESP = S_WR_RESP,
    DONE    = S_DONE
  } dma_state_e;

  dma_state_e            state;
  logic [MEM_ADDR_W-1:0] cur_src;
  logic [MEM_ADDR_W-1:0] cur_dst;
  logic [LEN_W-1:0]      remaining;

  logic resp_last_unused;
  assign resp_last_unused = mem_resp.resp_last;

  // Request fields are loaded on entry to a request state, so they hold
  // steady for however long the responder stalls ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done_irq       <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_resp_ready <= 1'b0;
      mem_req        <= '0;
      cur_src        <= '0;
      cur_dst        <= '0;
      remaining      <= '0;
    end else begin
      if (irq_clr) begin
        done_irq <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            cur_src   <= src_addr;
            cur_dst   <= dst_addr;
            remaining <= len;
            if (len == '0) begin
              state <= DONE;
            end else begin
              state            <= RD_REQ;
              mem_req_valid    <= 1'b1;
              mem_req.req_addr <= src_addr;
              mem_req.req_data <= '0;
              mem_req.req_mask <= '1;
              mem_req.req_type <= MEM_READ;
            end
          end
        end

        RD_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid  <= 1'b0;
            mem_resp_ready <= 1'b1;
            state          <= RD_RESP;
          end
        end

        // req_data doubles as the word buffer between read and write
        RD_RESP: begin
          if (mem_resp_valid) begin
            mem_resp_ready   <= 1'b0;
            mem_req_valid    <= 1'b1;
            mem_req.req_addr <= cur_dst;
            mem_req.req_data <= mem_resp.resp_data;
            mem_req.req_mask <= '1;
            mem_req.req_type <= MEM_WRITE;
            state            <= WR_REQ;
          end
        end

        WR_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid  <= 1'b0;
            mem_resp_ready <= 1'b1;
            state          <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (mem_resp_valid) begin
            mem_resp_ready <= 1'b0;
            remaining      <= remaining - LEN_W'(1);
            cur_src        <= cur_src + WORD_STRIDE;
            cur_dst        <= cur_dst + WORD_STRIDE;
            if (remaining == LEN_W'(1)) begin
              state <= DONE;
            end else begin
              state            <= RD_REQ;
              mem_req_valid    <= 1'b1;
              mem_req.req_addr <= cur_src + WORD_STRIDE;
              mem_req.req_data <= '0;
              mem_req.req_mask <= '1;
              mem_req.req_type <= MEM_READ;
            end
          end
        end

        // Placed after the irq_clr clear above so a coincident set wins
        DONE: begin
          done_irq <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma with a stallable mem_if responder model.
module tb_mem_copy_dma;
  import mem_copy_dma_pkg::*;

  localparam int unsigned LEN_W = 16;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  start;
  logic [MEM_ADDR_W-1:0] src_addr;
  logic [MEM_ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]      len;
  logic                  busy;
  logic                  done_irq;
  logic                  irq_clr;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  mem_req_t              mem_req;
  logic                  mem_resp_valid;
  logic                  mem_resp_ready;
  mem_resp_t             mem_resp;

  mem_copy_dma #(.LEN_W(LEN_W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .len            (len),
    .busy           (busy),
    .done_irq       (done_irq),
    .irq_clr        (irq_clr),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req        (mem_req),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp       (mem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [3:0]  mask;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] mem[logic [31:0]];
  int          req_stall = 0;
  int          resp_delay = 0;
  int          valid_cycles = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Responder: programmable ready stall and response delay; drives at negedge
  initial begin : responder
    int          phase;
    int          cnt;
    mem_req_t    held;
    logic [31:0] rd;
    phase = 0;
    cnt = 0;
    held = '0;
    rd = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid) valid_cycles++;
      if (!rstn) begin
        phase = 0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
      end else begin
        if (phase == 3) begin
          mem_resp_valid = 1'b0;
          phase = 0;
        end
        if (phase == 2) begin
          log_q.push_back('{held.req_addr, held.req_type == MEM_WRITE,
                            held.req_data, held.req_mask});
          if (held.req_type == MEM_WRITE) mem[held.req_addr] = held.req_data;
          else rd = mem_rd(held.req_addr);
          mem_req_ready = 1'b0;
          cnt = resp_delay;
          phase = 4;
        end
        if (phase == 4) begin
          if (cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp.resp_data = (held.req_type == MEM_WRITE) ? $urandom : rd;
            mem_resp.resp_last = 1'b1;
            phase = 3;
          end else begin
            cnt--;
          end
        end
        if (phase == 0) begin
          if (mem_req_valid) begin
            held = mem_req;
            if (req_stall == 0) begin
              mem_req_ready = 1'b1;
              phase = 2;
            end else begin
              cnt = req_stall;
              phase = 1;
            end
          end
        end else if (phase == 1) begin
          checks++;
          if (mem_req !== held || mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL req_stable: got valid=%0b req=%h expected valid=1 req=%h",
                     mem_req_valid, mem_req, held);
          end
          cnt--;
          if (cnt == 0) begin
            mem_req_ready = 1'b1;
            phase = 2;
          end
        end
      end
    end
  end

  task automatic clear_irq();
    @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    checks++;
    if (done_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clr: got done_irq=%0b expected 0", done_irq);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    start = 1'b0;
    irq_clr = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done_irq, mem_req_valid, mem_resp_ready} !== 4'b0 || mem_req !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%0b irq=%0b valid=%0b rready=%0b req=%h expected all 0",
               busy, done_irq, mem_req_valid, mem_resp_ready, mem_req);
    end
    rstn = 1'b1;
  endtask

  // Copy n words s->d; reference is the list of reads then writes per word
  task automatic run_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                          input int n, input int stall, input int rdly, input bit poke);
    txn_t exp_q[$];
    int   t0;
    int   bound;
    req_stall = stall;
    resp_delay = rdly;
    for (int i = 0; i < n; i++) mem[s + 32'(4 * i)] = $urandom;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{s + 32'(4 * i), 1'b0, 32'h0, 4'hF});
      exp_q.push_back('{d + 32'(4 * i), 1'b1, mem_rd(s + 32'(4 * i)), 4'hF});
    end
    log_q.delete();
    bound = n * (8 + stall + rdly) + 20;

    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len = LEN_W'(n);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    src_addr = $urandom;
    dst_addr = $urandom;
    len = LEN_W'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %0b expected 1", name, busy);
    end
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req.req_addr !== s || mem_req.req_type !== MEM_READ) begin
      errors++;
      $display("FAIL %s first_req: got valid=%0b addr=%h type=%0d expected valid=1 addr=%h type=0",
               name, mem_req_valid, mem_req.req_addr, mem_req.req_type, s);
    end

    while (done_irq !== 1'b1 && (cyc - t0) < bound) begin
      @(negedge clk);
      if (poke) begin
        if (cyc - t0 == 6) begin
          start = 1'b1;
          src_addr = 32'h900;
          dst_addr = 32'h980;
          len = LEN_W'(2);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (done_irq !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout: got done_irq=%0b after %0d cycles expected 1",
               name, done_irq, cyc - t0);
    end else if (stall == 0 && rdly == 0 && (cyc - t0) != 4 * n + 2) begin
      errors++;
      $display("FAIL %s done_latency: got %0d cycles expected %0d", name, cyc - t0, 4 * n + 2);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_done: got %0b expected 0", name, busy);
    end

    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s txn_count: got %0d expected %0d", name, log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= log_q.size()) begin
        errors++;
        $display("FAIL %s txn%0d: got none expected addr=%h wr=%0b", name, i,
                 exp_q[i].addr, exp_q[i].wr);
      end else if (log_q[i].addr !== exp_q[i].addr || log_q[i].wr !== exp_q[i].wr ||
                   log_q[i].mask !== exp_q[i].mask ||
                   (exp_q[i].wr && log_q[i].data !== exp_q[i].data)) begin
        errors++;
        $display("FAIL %s txn%0d: got addr=%h wr=%0b data=%h mask=%h expected addr=%h wr=%0b data=%h mask=%h",
                 name, i, log_q[i].addr, log_q[i].wr, log_q[i].data, log_q[i].mask,
                 exp_q[i].addr, exp_q[i].wr, exp_q[i].data, exp_q[i].mask);
      end
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mem_rd(d + 32'(4 * i)) !== mem_rd(s + 32'(4 * i))) begin
        errors++;
        $display("FAIL %s dst_word%0d: got %h expected %h", name, i,
                 mem_rd(d + 32'(4 * i)), mem_rd(s + 32'(4 * i)));
      end
    end
    clear_irq();
    req_stall = 0;
    resp_delay = 0;
  endtask

  task automatic test_basic_copy();
    run_copy("basic", 32'h100, 32'h200, 4, 0, 0, 1'b0);
  endtask

  task automatic test_len_zero();
    int vc0;
    vc0 = valid_cycles;
    @(negedge clk);
    src_addr = 32'h100;
    dst_addr = 32'h200;
    len = '0;
    start = 1'b1;
    @(negedge clk);
    // This is the DONE cycle; a start here must be ignored
    src_addr = 32'h500;
    len = LEN_W'(2);
    checks++;
    if (busy !== 1'b1 || done_irq !== 1'b0) begin
      errors++;
      $display("FAIL len0_cycle1: got busy=%0b irq=%0b expected busy=1 irq=0", busy, done_irq);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done_irq !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_cycle2: got busy=%0b irq=%0b expected busy=0 irq=1", busy, done_irq);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (valid_cycles != vc0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_quiet: got valid_cycles=%0d busy=%0b expected %0d busy=0",
               valid_cycles - vc0, busy, 0);
    end
    clear_irq();
  endtask

  task automatic test_stall();
    run_copy("stall", 32'h100, 32'h200, 4, 5, 0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_copy("busy_start", 32'h400, 32'h600, 5, 1, 2, 1'b1);
  endtask

  task automatic test_addr_wrap();
    run_copy("wrap", 32'hFFFF_FFF8, 32'h0000_3000, 3, 0, 0, 1'b0);
    checks++;
    if (log_q.size() < 5 || log_q[4].addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_third_read: got size=%0d addr=%h expected addr=00000000",
               log_q.size(), (log_q.size() < 5) ? 32'hx : log_q[4].addr);
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    req_stall = 5;
    log_q.delete();
    @(negedge clk);
    src_addr = 32'h100;
    dst_addr = 32'h200;
    len = LEN_W'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!(mem_req_valid === 1'b1 && mem_req.req_type === MEM_WRITE) && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 60) begin
      errors++;
      $display("FAIL rst_mid_wait: got no write request in %0d cycles expected one", waited);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done_irq, mem_req_valid, mem_resp_ready} !== 4'b0 || mem_req !== '0) begin
      errors++;
      $display("FAIL rst_mid: got busy=%0b irq=%0b valid=%0b rready=%0b req=%h expected all 0",
               busy, done_irq, mem_req_valid, mem_resp_ready, mem_req);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    req_stall = 0;
  endtask

  task automatic test_irq_clr_race();
    @(negedge clk);
    len = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    checks++;
    if (done_irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_race: got done_irq=%0b expected 1", done_irq);
    end
    clear_irq();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      int n;
      int st;
      int rd;
      logic [31:0] s;
      logic [31:0] d;
      n  = $urandom_range(1, 6);
      st = (k == 0) ? 0 : $urandom_range(0, 3);
      rd = (k == 0) ? 0 : $urandom_range(0, 3);
      s  = 32'h1000 + 32'($urandom_range(0, 255) << 2);
      d  = 32'h8000 + 32'($urandom_range(0, 255) << 2);
      run_copy($sformatf("b2b%0d", k), s, d, n, st, rd, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_len_zero();
    test_stall();
    test_start_while_busy();
    test_addr_wrap();
    test_reset_mid();
    test_basic_copy();
    test_irq_clr_race();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
